// File: rtl/flappy_display_pkg.sv
// Shared definitions for the flappy_display slice: VGA 640x480@60 timing,
// screen geometry, colour constants and game state encoding.
package flappy_display_pkg;

    // Horizontal timing, in pixel ticks
    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    // Vertical timing, in lines
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned SCREEN_W = H_VISIBLE;
    localparam int unsigned SCREEN_H = V_VISIBLE;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    localparam rgb_t COL_BLANK    = 12'h000;
    localparam rgb_t COL_BIRD     = 12'hFF0;
    localparam rgb_t COL_PIPE     = 12'h0C0;
    localparam rgb_t COL_SKY      = 12'h4AF;
    localparam rgb_t COL_SKY_OVER = 12'h800;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } state_t;

endpackage

// File: rtl/flappy_display_vga_timing.sv
// 640x480@60 raster counters with combinational sync, visible and
// frame-event decodes. Counters advance only on pix_en.
module flappy_display_vga_timing
    import flappy_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hsync_pre,
    output logic       vsync_pre,
    output logic       visible,
    output logic       frame_evt
);

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);

    // Raster position: hcnt wraps each line, vcnt steps on the hcnt wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pix_en) begin
            if (hcnt == H_LAST) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
            end else begin
                hcnt <= hcnt + 10'd1;
            end
        end
    end

    // Decodes of the current raster position
    always_comb begin
        hsync_pre = !((hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END));
        vsync_pre = !((vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END));
        visible   = (hcnt < H_VIS) && (vcnt < V_VIS);
        frame_evt = pix_en && (hcnt == '0) && (vcnt == V_VIS);
    end

endmodule

// File: rtl/flappy_display.sv
// Flappy display top: VGA output, pillar scrolling, per-frame collision,
// IDLE/PLAY/OVER game FSM and saturating score.
module flappy_display
    import flappy_display_pkg::*;
#(
    parameter int unsigned BIRD_X       = 160,
    parameter int unsigned BIRD_SZ      = 16,
    parameter int unsigned PIPE_W       = 40,
    parameter int unsigned GAP_H        = 60,
    parameter int unsigned SCROLL       = 2,
    parameter int unsigned PIPE_SPACING = 340
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_en,
    input  logic              start,
    input  logic signed [9:0] y,
    input  logic        [9:0] p1,
    input  logic        [9:0] p2,
    output logic              hsync,
    output logic              vsync,
    output logic        [3:0] r,
    output logic        [3:0] g,
    output logic        [3:0] b,
    output logic        [7:0] score,
    output logic              game_over
);

    localparam logic        [10:0] PX_WRAP  = 11'(H_VISIBLE + PIPE_W);
    localparam logic        [10:0] PX2_INIT = 11'(H_VISIBLE + PIPE_W + PIPE_SPACING);
    localparam logic        [10:0] PX_STEP  = 11'(SCROLL);
    localparam logic        [10:0] BX_LO    = 11'(BIRD_X);
    localparam logic        [10:0] BX_HI    = 11'(BIRD_X + BIRD_SZ);
    localparam logic        [10:0] PW       = 11'(PIPE_W);
    localparam logic signed [10:0] B_HALF   = 11'(BIRD_SZ / 2);
    localparam logic signed [10:0] ROW_MAX  = 11'(SCREEN_H - 1);
    localparam logic signed [10:0] Y_TOP    = 11'(SCREEN_H);
    localparam logic signed [11:0] ROW_MAX12 = 12'(SCREEN_H - 1);
    localparam logic signed [11:0] GH       = 12'(GAP_H);
    localparam logic        [9:0]  GAP_INIT = 10'(SCREEN_H / 2);

    logic [9:0]  hcnt, vcnt;
    logic        hsync_pre, vsync_pre, visible, frame_evt;

    state_t      state, state_nxt;
    logic [10:0] px1, px2, px1_nxt, px2_nxt;
    logic [9:0]  gap1, gap2;
    logic [7:0]  score_q, score_nxt;
    logic        hit;
    logic        wrap1, wrap2, cross1, cross2;
    logic [8:0]  score_sum;

    logic [10:0]        col;
    logic signed [10:0] y_ext, yc, brow, row_s;
    logic               in_bird, in_pipe, y_out;
    rgb_t               pix;

    flappy_display_vga_timing u_timing (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .hcnt      (hcnt),
        .vcnt      (vcnt),
        .hsync_pre (hsync_pre),
        .vsync_pre (vsync_pre),
        .visible   (visible),
        .frame_evt (frame_evt)
    );

    // Pillar cols [px-PIPE_W, px), solid except within GAP_H rows of the gap centre
    function automatic logic pillar_at(input logic [10:0] c, input logic [9:0] row,
                                       input logic [10:0] px, input logic [9:0] gap);
        logic signed [11:0] rs, gs, d;
        rs = {2'b00, row};
        gs = {2'b00, gap};
        d  = rs + gs - ROW_MAX12;
        return ((c + PW) >= px) && (c < px) && ((d > GH) || (d < -GH));
    endfunction

    // Bird/pillar hit-testing of the current raster pixel
    always_comb begin
        col   = {1'b0, hcnt};
        row_s = {1'b0, vcnt};
        y_ext = {y[9], y};
        if (y_ext[10])
            yc = '0;
        else if (y_ext > ROW_MAX)
            yc = ROW_MAX;
        else
            yc = y_ext;
        brow    = ROW_MAX - yc;
        in_bird = (col >= BX_LO) && (col < BX_HI) &&
                  (row_s >= brow - B_HALF) && (row_s < brow + B_HALF);
        in_pipe = pillar_at(col, vcnt, px1, gap1) || pillar_at(col, vcnt, px2, gap2);
        y_out   = y_ext[10] || (y_ext == '0) || (y_ext >= Y_TOP);
    end

    // Colour priority: blanking, bird, pillar, sky
    always_comb begin
        if (!visible)
            pix = COL_BLANK;
        else if (in_bird)
            pix = COL_BIRD;
        else if (in_pipe)
            pix = COL_PIPE;
        else if (state == OVER)
            pix = COL_SKY_OVER;
        else
            pix = COL_SKY;
    end

    // Output register keeps sync and colour aligned at one tick of latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            {r, g, b} <= '0;
        end else if (pix_en) begin
            hsync     <= hsync_pre;
            vsync     <= vsync_pre;
            {r, g, b} <= pix;
        end
    end

    // Collision accumulator over the visible frame, consumed at the frame event
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hit <= 1'b0;
        else if (frame_evt)
            hit <= 1'b0;
        else if (pix_en && visible && (state == PLAY) && ((in_bird && in_pipe) || y_out))
            hit <= 1'b1;
    end

    // Per-frame scroll step, wrap and bird-crossing score increments
    always_comb begin
        wrap1     = px1 <= PX_STEP;
        wrap2     = px2 <= PX_STEP;
        px1_nxt   = wrap1 ? PX_WRAP : px1 - PX_STEP;
        px2_nxt   = wrap2 ? PX_WRAP : px2 - PX_STEP;
        cross1    = !wrap1 && (px1 >= BX_LO) && (px1_nxt < BX_LO);
        cross2    = !wrap2 && (px2 >= BX_LO) && (px2_nxt < BX_LO);
        score_sum = {1'b0, score_q} + {8'd0, cross1} + {8'd0, cross2};
        score_nxt = score_sum[8] ? 8'hFF : score_sum[7:0];
    end

    // Game state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Game state transitions at the frame event; hit outranks start in PLAY
    always_comb begin
        state_nxt = state;
        game_over = (state == OVER);
        score     = score_q;
        if (frame_evt) begin
            case (state)
                IDLE, OVER: if (start) state_nxt = PLAY;
                PLAY:       if (hit)   state_nxt = OVER;
                default:    state_nxt = IDLE;
            endcase
        end
    end

    // Pillar positions, latched gaps and score, all updated at the frame event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px1     <= PX_WRAP;
            px2     <= PX2_INIT;
            gap1    <= GAP_INIT;
            gap2    <= GAP_INIT;
            score_q <= '0;
        end else if (frame_evt) begin
            if (state != PLAY) begin
                if (start) begin
                    px1     <= PX_WRAP;
                    px2     <= PX2_INIT;
                    gap1    <= GAP_INIT;
                    gap2    <= GAP_INIT;
                    score_q <= '0;
                end
            end else if (!hit) begin
                px1     <= px1_nxt;
                px2     <= px2_nxt;
                score_q <= score_nxt;
                if (wrap1) gap1 <= p1;
                if (wrap2) gap2 <= p2;
            end
        end
    end

endmodule
